// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core start/ready word bus and its
// Avalon-MM bridge.
//
// Contents:
//   word_addr_t    - 30-bit word address used on the core side
//   word_t         - 32-bit data word
//   bridge_state_t - bridge FSM states
//   BYTEEN_ALL     - full-word Avalon byte enable
//   word_to_byte_addr() - word address to Avalon byte address
package core_bus_pkg;

   typedef logic [29:0] word_addr_t;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RDWAIT,
      RESP
   } bridge_state_t;

   localparam logic [3:0] BYTEEN_ALL = 4'b1111;

   // Core addresses whole words; Avalon addresses bytes.
   function automatic word_t word_to_byte_addr(input word_addr_t waddr);
      return {waddr, 2'b00};
   endfunction

endpackage

// File: rtl/core_avalon_bridge_if.sv
// Avalon-MM master-side bus bundle between core_avalon_bridge and the
// platform interconnect.
//
// Signals:
//   avl_address       byte address              (master -> slave)
//   avl_read          read request              (master -> slave)
//   avl_write         write request             (master -> slave)
//   avl_writedata     write data                (master -> slave)
//   avl_byteenable    byte enables              (master -> slave)
//   avl_waitrequest   slave stall               (slave -> master)
//   avl_readdata      read data                 (slave -> master)
//   avl_readdatavalid read data strobe          (slave -> master)
//
// Modports: master (the bridge), slave (the interconnect or a bench model).
interface core_avalon_bridge_if;
   import core_bus_pkg::*;

   word_t      avl_address;
   logic       avl_read;
   logic       avl_write;
   word_t      avl_writedata;
   logic [3:0] avl_byteenable;
   logic       avl_waitrequest;
   word_t      avl_readdata;
   logic       avl_readdatavalid;

   modport master (
      output avl_address,
      output avl_read,
      output avl_write,
      output avl_writedata,
      output avl_byteenable,
      input  avl_waitrequest,
      input  avl_readdata,
      input  avl_readdatavalid
   );

   modport slave (
      input  avl_address,
      input  avl_read,
      input  avl_write,
      input  avl_writedata,
      input  avl_byteenable,
      output avl_waitrequest,
      output avl_readdata,
      output avl_readdatavalid
   );

endinterface

// File: rtl/bridge_watchdog.sv
// Per-transaction watchdog for core_avalon_bridge.
//
// Counts clock cycles while enabled and flags expiry once the count reaches
// TIMEOUT_CYCLES-1. The count saturates at the limit so the flag stays set
// until the next clear.
//
// Ports:
//   clk      input   clock
//   rst      input   synchronous active-high reset
//   clear    input   restart the count from zero (has priority over enable)
//   enable   input   count this cycle
//   expired  output  count has reached TIMEOUT_CYCLES-1
module bridge_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = (cnt_q == LIMIT);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/core_avalon_bridge.sv
// Bus responder for the core's start/ready word bus. Each core_start pulse
// is latched and replayed as a single Avalon-MM read or write; completion is
// reported with a one-cycle core_ready pulse. One transaction in flight at a
// time, no bursts, no pipelining. All outputs come straight from flops.
//
// Build option: define CORE_BRIDGE_TIMEOUT_EN to add a per-transaction
// watchdog. On expiry the pending request is dropped and the transaction
// completes with core_err=1 (reads return ERR_DATA). Without the macro the
// bridge waits indefinitely and core_err is always 0.
//
// Ports:
//   clk           input   clock, all logic on posedge
//   rst           input   synchronous active-high reset
//   core_addr     input   word address, sampled on core_start
//   core_data_wr  input   write data, sampled on core_start
//   core_write    input   1=write 0=read, sampled on core_start
//   core_start    input   one-cycle request pulse (honoured only when idle)
//   core_ready    output  one-cycle completion pulse
//   core_data_rd  output  last read data, held until the next read completes
//   core_err      output  one-cycle pulse with core_ready on timeout
//   avl           master  Avalon-MM bus (see core_avalon_bridge_if)
module core_avalon_bridge
   import core_bus_pkg::*;
#(
   parameter int    TIMEOUT_CYCLES = 1024,
   parameter word_t ERR_DATA       = 32'hDEADBEEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  word_addr_t                  core_addr,
   input  word_t                       core_data_wr,
   input  logic                        core_write,
   input  logic                        core_start,
   output logic                        core_ready,
   output word_t                       core_data_rd,
   output logic                        core_err,
   core_avalon_bridge_if.master        avl
);

   bridge_state_t state_q, state_d;
   logic          is_write_q, is_write_d;
   logic          avl_read_q, avl_read_d;
   logic          avl_write_q, avl_write_d;
   word_t         avl_address_q, avl_address_d;
   word_t         avl_writedata_q, avl_writedata_d;
   word_t         core_data_rd_q, core_data_rd_d;
   logic          core_ready_q, core_ready_d;
   logic          core_err_q, core_err_d;
   logic          timeout_hit;

`ifdef CORE_BRIDGE_TIMEOUT_EN
   logic wd_clear;
   logic wd_enable;
   logic wd_expired;

   // Restart the count on the IDLE->REQ transition so the first REQ cycle
   // sees zero; count every cycle spent waiting on the slave.
   assign wd_clear  = (state_q == IDLE) && core_start;
   assign wd_enable = (state_q == REQ) || (state_q == RDWAIT);

   bridge_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   assign timeout_hit = wd_expired;
`else
   // The limit only matters with the watchdog built in; kept as a parameter
   // so both builds share one instantiation footprint.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      is_write_d      = is_write_q;
      avl_read_d      = avl_read_q;
      avl_write_d     = avl_write_q;
      avl_address_d   = avl_address_q;
      avl_writedata_d = avl_writedata_q;
      core_data_rd_d  = core_data_rd_q;
      core_ready_d    = 1'b0;
      core_err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (core_start) begin
               is_write_d      = core_write;
               avl_address_d   = word_to_byte_addr(core_addr);
               avl_writedata_d = core_data_wr;
               avl_write_d     = core_write;
               avl_read_d      = !core_write;
               state_d         = REQ;
            end
         end

         REQ: begin
            // Acceptance takes priority over a coincident watchdog expiry.
            if (!avl.avl_waitrequest) begin
               avl_read_d  = 1'b0;
               avl_write_d = 1'b0;
               if (is_write_q) begin
                  core_ready_d = 1'b1;
                  state_d      = RESP;
               end else if (avl.avl_readdatavalid) begin
                  // Zero-latency slave: data returned with the accept.
                  core_data_rd_d = avl.avl_readdata;
                  core_ready_d   = 1'b1;
                  state_d        = RESP;
               end else begin
                  state_d = RDWAIT;
               end
            end else if (timeout_hit) begin
               avl_read_d   = 1'b0;
               avl_write_d  = 1'b0;
               core_ready_d = 1'b1;
               core_err_d   = 1'b1;
               if (!is_write_q) begin
                  core_data_rd_d = ERR_DATA;
               end
               state_d = RESP;
            end
         end

         RDWAIT: begin
            // Late data in the expiry cycle still counts as a normal finish.
            if (avl.avl_readdatavalid) begin
               core_data_rd_d = avl.avl_readdata;
               core_ready_d   = 1'b1;
               state_d        = RESP;
            end else if (timeout_hit) begin
               core_data_rd_d = ERR_DATA;
               core_ready_d   = 1'b1;
               core_err_d     = 1'b1;
               state_d        = RESP;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         is_write_q      <= 1'b0;
         avl_read_q      <= 1'b0;
         avl_write_q     <= 1'b0;
         avl_address_q   <= '0;
         avl_writedata_q <= '0;
         core_data_rd_q  <= '0;
         core_ready_q    <= 1'b0;
         core_err_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         is_write_q      <= is_write_d;
         avl_read_q      <= avl_read_d;
         avl_write_q     <= avl_write_d;
         avl_address_q   <= avl_address_d;
         avl_writedata_q <= avl_writedata_d;
         core_data_rd_q  <= core_data_rd_d;
         core_ready_q    <= core_ready_d;
         core_err_q      <= core_err_d;
      end
   end

   assign core_ready         = core_ready_q;
   assign core_data_rd       = core_data_rd_q;
   assign core_err           = core_err_q;
   assign avl.avl_address    = avl_address_q;
   assign avl.avl_read       = avl_read_q;
   assign avl.avl_write      = avl_write_q;
   assign avl.avl_writedata  = avl_writedata_q;
   assign avl.avl_byteenable = BYTEEN_ALL;

   // A start while busy is dropped by the FSM; flag it to the core designer.
   assert property (@(posedge clk) disable iff (rst)
                    core_start |-> (state_q == IDLE))
      else $warning("core_avalon_bridge: core_start while busy ignored");

endmodule
